// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared constants and types for the ADC result readout path.
//   NUM_ADC  : number of ADC channels in the result bank
//   ADC_BITS : bits per ADC result
//   CHAN_W   : channel index width, clog2(NUM_ADC)
// Types: chan_t, sample_t, mask_t, reader_state_t.
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int NUM_ADC  = 8;
  localparam int ADC_BITS = 10;
  localparam int CHAN_W   = 3;
  localparam int BANK_W   = NUM_ADC * ADC_BITS;

  typedef logic [CHAN_W-1:0]   chan_t;
  typedef logic [ADC_BITS-1:0] sample_t;
  typedef logic [NUM_ADC-1:0]  mask_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } reader_state_t;

endpackage

// File: rtl/adc_next_chan.sv
// ---------------------------------------------------------------------------
// adc_next_chan
// Combinational channel search over an enable mask.
// Ports:
//   i_mask  : per-channel enable mask
//   i_cur   : current channel index
//   o_next  : lowest set mask bit strictly above i_cur (0 when none)
//   o_found : 1 when o_next is valid, i.e. a higher enabled channel exists
//   o_first : lowest set mask bit overall (0 when the mask is empty)
// ---------------------------------------------------------------------------
module adc_next_chan
  import adc_pkg::*;
(
  input  logic [NUM_ADC-1:0] i_mask,
  input  logic [CHAN_W-1:0]  i_cur,
  output logic [CHAN_W-1:0]  o_next,
  output logic               o_found,
  output logic [CHAN_W-1:0]  o_first
);

  // Scan from the top channel down so that the last hit written is the
  // lowest qualifying index, giving a simple priority encoder for both
  // the "first set bit" and the "next set bit above the current one".
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    o_first = '0;
    for (int i = NUM_ADC - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first = chan_t'(i);
        if (i > int'(i_cur)) begin
          o_next  = chan_t'(i);
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_reader.sv
// ---------------------------------------------------------------------------
// adc_reader
// On a start strobe, snapshots the ADC result bank and channel-enable mask,
// then streams one result word per enabled channel in ascending channel
// order over a valid/ready interface.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bank        : NUM_ADC x ADC_BITS result bank, ADCn at [n*ADC_BITS +: ADC_BITS]
//   en_mask     : per-channel read enable
//   start       : one-cycle strobe to begin readout
//   m_valid/m_ready/m_data/m_chan/m_last : output word stream
//   busy        : high while words are being streamed
//   done        : one-cycle pulse after the set finishes
// Optional (macro ADC_READER_OVERRUN_EN):
//   overrun     : sticky flag, set by a start arriving while streaming
//   overrun_cnt : saturating count of such starts
// ---------------------------------------------------------------------------
module adc_reader
  import adc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_ADC*ADC_BITS-1:0] bank,
  input  logic [NUM_ADC-1:0]          en_mask,
  input  logic                        start,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ADC_BITS-1:0]         m_data,
  output logic [CHAN_W-1:0]           m_chan,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
`ifdef ADC_READER_OVERRUN_EN
  ,
  output logic                        overrun,
  output logic [7:0]                  overrun_cnt
`endif
);

  reader_state_t r_state;
  sample_t       r_bank [NUM_ADC];
  mask_t         r_mask;
  chan_t         r_chan;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic          w_handshake;
  mask_t         w_searchMask;
  chan_t         w_next;
  logic          w_found;
  chan_t         w_first;

  // One search block serves both jobs: while streaming it walks the
  // snapshot mask from the current channel, otherwise it looks at the
  // live en_mask so the first channel is ready to load on start.
  assign w_searchMask = (r_state == SEND) ? r_mask : en_mask;
  assign w_handshake  = r_valid & m_ready;

  adc_next_chan u_nextChan (
    .i_mask  (w_searchMask),
    .i_cur   (r_chan),
    .o_next  (w_next),
    .o_found (w_found),
    .o_first (w_first)
  );

  // Main readout FSM. IDLE and FIN both accept a start so that sets can be
  // chained back to back with no idle gap. An empty mask skips straight to
  // FIN so the requester still sees a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int n = 0; n < NUM_ADC; n++) begin
        r_bank[n] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          if (start) begin
            if (en_mask != '0) begin
              for (int n = 0; n < NUM_ADC; n++) begin
                r_bank[n] <= bank[n*ADC_BITS +: ADC_BITS];
              end
              r_mask  <= en_mask;
              r_chan  <= w_first;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= SEND;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (w_handshake) begin
            if (w_found) begin
              r_chan <= w_next;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADC_READER_OVERRUN_EN
  logic [7:0] r_overrunCnt;
  logic       r_overrun;

  // A start that lands while a set is still streaming is dropped by the
  // FSM; here it is recorded so the host can tell it lost a readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun    <= 1'b0;
      r_overrunCnt <= '0;
    end else if (start && (r_state == SEND)) begin
      r_overrun <= 1'b1;
      if (r_overrunCnt != 8'hFF) begin
        r_overrunCnt <= r_overrunCnt + 8'd1;
      end
    end
  end

  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrunCnt;
`endif

  // m_last is only meaningful alongside m_valid; outside SEND the search
  // block looks at en_mask, so it is gated to avoid a spurious last flag.
  assign m_valid = r_valid;
  assign m_data  = r_bank[r_chan];
  assign m_chan  = r_chan;
  assign m_last  = r_valid & ~w_found;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_adc_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_reader
// Self-checking bench for adc_reader. Each readout set is modelled as a
// queue of (channel, word) pairs built from the mask and bank at start time;
// the stream is compared against that queue beat by beat under various
// m_ready patterns. Overrun outputs are checked when ADC_READER_OVERRUN_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_adc_reader;
  import adc_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_ADC*ADC_BITS-1:0] bank;
  logic [NUM_ADC-1:0]          en_mask;
  logic                        start;
  logic                        m_valid;
  logic                        m_ready;
  logic [ADC_BITS-1:0]         m_data;
  logic [CHAN_W-1:0]           m_chan;
  logic                        m_last;
  logic                        busy;
  logic                        done;
`ifdef ADC_READER_OVERRUN_EN
  logic                        overrun;
  logic [7:0]                  overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int expOverrunCnt = 0;

  logic [NUM_ADC*ADC_BITS-1:0] fullBank;

  adc_reader dut (
    .clk     (clk),
    .rst     (rst),
    .bank    (bank),
    .en_mask (en_mask),
    .start   (start),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_chan  (m_chan),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
`ifdef ADC_READER_OVERRUN_EN
    ,
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge, so both
  // driving inputs and sampling outputs happen away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_ADC*ADC_BITS-1:0] randomBank();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    return raw[NUM_ADC*ADC_BITS-1:0];
  endfunction

  // All outputs must read zero right after a reset edge.
  task automatic checkReset();
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_data",  32'(m_data),  32'd0);
    checkOutput("rst_chan",  32'(m_chan),  32'd0);
    checkOutput("rst_last",  32'(m_last),  32'd0);
    checkOutput("rst_busy",  32'(busy),    32'd0);
    checkOutput("rst_done",  32'(done),    32'd0);
  endtask

  // One quiet cycle after a set: done must have dropped back after one cycle.
  task automatic idleGap();
    m_ready = 1'b0;
    start   = 1'b0;
    step();
    checkOutput("gap_done",  32'(done),    32'd0);
    checkOutput("gap_valid", 32'(m_valid), 32'd0);
    checkOutput("gap_busy",  32'(busy),    32'd0);
  endtask

  // Runs one readout set. readyMode: 0 = always ready, 1 = toggle 1/0,
  // 2 = random. midStart issues a second start (with new inputs) while
  // the first set is still streaming. Ends in the cycle where done is
  // expected high, so a caller may chain another set straight away.
  task automatic applyStimulus(input logic [NUM_ADC-1:0] mask,
                               input logic [NUM_ADC*ADC_BITS-1:0] bankVal,
                               input int readyMode, input bit midStart);
    int expChan[$];
    int expData[$];
    bit rdy;
    int cyc;
    for (int n = 0; n < NUM_ADC; n++) begin
      if (mask[n]) begin
        expChan.push_back(n);
        expData.push_back(int'(bankVal[n*ADC_BITS +: ADC_BITS]));
      end
    end

    en_mask = mask;
    bank    = bankVal;
    start   = 1'b1;
    m_ready = 1'b0;
    step();
    start   = 1'b0;
    en_mask = NUM_ADC'($urandom);
    bank    = randomBank();

    cyc = 0;
    while (expChan.size() > 0 && cyc < 200) begin
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom % 2);
      endcase
      m_ready = rdy;
      if (midStart && cyc == 1) begin
        start   = 1'b1;
        en_mask = NUM_ADC'($urandom);
        bank    = randomBank();
        if (expOverrunCnt < 255) expOverrunCnt++;
      end else begin
        start = 1'b0;
      end
      checkOutput("beat_valid", 32'(m_valid), 32'd1);
      checkOutput("beat_chan",  32'(m_chan),  32'(expChan[0]));
      checkOutput("beat_data",  32'(m_data),  32'(expData[0]));
      checkOutput("beat_last",  32'(m_last),  32'(expChan.size() == 1));
      checkOutput("beat_busy",  32'(busy),    32'd1);
      checkOutput("beat_done",  32'(done),    32'd0);
      step();
      if (rdy) begin
        void'(expChan.pop_front());
        void'(expData.pop_front());
      end
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    if (expChan.size() != 0) begin
      checkOutput("beat_timeout", 32'(expChan.size()), 32'd0);
    end
    checkOutput("fin_done",  32'(done),    32'd1);
    checkOutput("fin_valid", 32'(m_valid), 32'd0);
    checkOutput("fin_busy",  32'(busy),    32'd0);
  endtask

`ifdef ADC_READER_OVERRUN_EN
  task automatic checkOverrun(input string tag);
    checkOutput({tag, "_flag"}, 32'(overrun),     32'(expOverrunCnt != 0));
    checkOutput({tag, "_cnt"},  32'(overrun_cnt), 32'(expOverrunCnt));
  endtask
`endif

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    en_mask = '0;
    bank    = '0;
    for (int n = 0; n < NUM_ADC; n++) begin
      fullBank[n*ADC_BITS +: ADC_BITS] = ADC_BITS'(10'h100 + n);
    end

    // Reset state.
    step();
    step();
    checkReset();
`ifdef ADC_READER_OVERRUN_EN
    checkOverrun("rst_ovr");
`endif
    rst = 1'b0;
    step();

    // Full mask at full throughput: chan 0..7, data 0x100..0x107.
    applyStimulus(8'hFF, fullBank, 0, 1'b0);
    idleGap();

    // Sparse mask with toggling backpressure: chan 2, 5, 7 only.
    applyStimulus(8'b1010_0100, randomBank(), 1, 1'b0);
    idleGap();

    // Empty mask: done the cycle after start, no beats, never busy.
    applyStimulus(8'h00, randomBank(), 0, 1'b0);
    idleGap();

    // Start while streaming plus input changes: snapshot is unaffected.
    applyStimulus(8'hFF, randomBank(), 2, 1'b1);
`ifdef ADC_READER_OVERRUN_EN
    checkOverrun("mid_ovr");
`endif
    idleGap();

    // Reset during the third beat abandons the set without done.
    en_mask = 8'hFF;
    bank    = fullBank;
    start   = 1'b1;
    step();
    start   = 1'b0;
    m_ready = 1'b1;
    checkOutput("rs_chan0", 32'(m_chan), 32'd0);
    step();
    checkOutput("rs_chan1", 32'(m_chan), 32'd1);
    step();
    checkOutput("rs_chan2", 32'(m_chan), 32'd2);
    rst = 1'b1;
    step();
    checkReset();
    expOverrunCnt = 0;
`ifdef ADC_READER_OVERRUN_EN
    checkOverrun("rs_ovr");
`endif
    rst     = 1'b0;
    m_ready = 1'b0;
    step();
    checkOutput("rs_nodone",  32'(done),    32'd0);
    checkOutput("rs_novalid", 32'(m_valid), 32'd0);
    applyStimulus(8'hFF, fullBank, 0, 1'b0);
    idleGap();

    // Back-to-back sets: second start issued in the FIN cycle.
    applyStimulus(8'h0F, randomBank(), 0, 1'b0);
    applyStimulus(8'hF0, randomBank(), 0, 1'b0);
    idleGap();

    // Randomised sets, some chained, some with overlapping starts.
    for (int k = 0; k < 30; k++) begin
      applyStimulus(NUM_ADC'($urandom), randomBank(), 2, 1'($urandom % 2));
      if ($urandom % 2 == 1) idleGap();
    end
    idleGap();
`ifdef ADC_READER_OVERRUN_EN
    checkOverrun("end_ovr");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
